// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if
//   EX-stage branch request and redirect response bundle.
//   master: the pipeline side, which presents a resolved instruction and receives the redirect.
//   slave:  the branch resolve unit.
//
//   in_valid       master->slave  branch/jump instruction present in EX
//   stall          master->slave  pipeline freeze
//   pc             master->slave  PC of the EX instruction
//   val1           master->slave  first operand
//   src2_val       master->slave  second operand
//   branch_type    master->slave  condition selector
//   target         master->slave  taken target
//   pred_taken     master->slave  fetch-time prediction
//   branch_taken   slave->master  combinational condition result
//   redirect_valid slave->master  registered one-cycle mispredict pulse
//   redirect_pc    slave->master  registered correct next PC
interface branch_resolve_unit_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PC_WIDTH = 32
);
    logic                in_valid;
    logic                stall;
    logic [PC_WIDTH-1:0] pc;
    logic [WIDTH-1:0]    val1;
    logic [WIDTH-1:0]    src2_val;
    logic [2:0]          branch_type;
    logic [PC_WIDTH-1:0] target;
    logic                pred_taken;
    logic                branch_taken;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;

    modport master (
        output in_valid,
        output stall,
        output pc,
        output val1,
        output src2_val,
        output branch_type,
        output target,
        output pred_taken,
        input  branch_taken,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  in_valid,
        input  stall,
        input  pc,
        input  val1,
        input  src2_val,
        input  branch_type,
        input  target,
        input  pred_taken,
        output branch_taken,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   EX-stage branch resolution. Evaluates the branch condition, compares it against the
//   fetch-time prediction and raises a registered one-cycle redirect on a mismatch. Owns a
//   bimodal BHT of 2-bit saturating counters (read by fetch, written by EX) and saturating
//   branch / mispredict statistics counters.
//
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   if_pc            fetch PC used for the BHT lookup
//   if_pred_taken    combinational prediction (MSB of the indexed BHT counter)
//   ex               EX request / redirect bundle (slave side)
//   branch_count     resolved branches, saturating
//   mispredict_count mispredicts, saturating
module branch_resolve_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned BHT_DEPTH = 16,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PC_WIDTH-1:0]  if_pc,
    output logic                 if_pred_taken,
    branch_resolve_unit_if.slave ex,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    localparam logic [2:0] TYPE_NONE = 3'b000;
    localparam logic [2:0] TYPE_BEZ  = 3'b001;
    localparam logic [2:0] TYPE_BNE  = 3'b010;
    localparam logic [2:0] TYPE_JMP  = 3'b011;
    localparam logic [2:0] TYPE_BEQ  = 3'b100;
    localparam logic [2:0] TYPE_BLT  = 3'b101;
    localparam logic [2:0] TYPE_BGE  = 3'b110;
    localparam logic [2:0] TYPE_BLTU = 3'b111;

    logic [1:0]           bht_q [BHT_DEPTH];
    logic                 redirect_valid_q;
    logic [PC_WIDTH-1:0]  redirect_pc_q;
    logic [CNT_WIDTH-1:0] branch_count_q;
    logic [CNT_WIDTH-1:0] mispredict_count_q;

    logic                 cond;
    logic                 taken;
    logic                 accept;
    logic                 is_branch;
    logic                 is_conditional;
    logic                 mispredict;
    logic                 bht_update;
    logic [PC_WIDTH-1:0]  next_pc;
    logic [IDX_W-1:0]     if_idx;
    logic [IDX_W-1:0]     ex_idx;
    logic [1:0]           bht_cur;
    logic [1:0]           bht_next;

    // Only the word-index bits of the fetch PC address the BHT.
    logic unused_if_pc;
    assign unused_if_pc = ^{if_pc[PC_WIDTH-1:IDX_W+2], if_pc[1:0]};

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex.pc[IDX_W+1:2];

    // Fetch read sees the stored value; an EX write in the same cycle lands at the edge.
    assign if_pred_taken = bht_q[if_idx][1];

    always_comb begin
        cond = 1'b0;
        unique case (ex.branch_type)
            TYPE_NONE: cond = 1'b0;
            TYPE_BEZ:  cond = (ex.val1 == '0);
            TYPE_BNE:  cond = (ex.val1 != ex.src2_val);
            TYPE_JMP:  cond = 1'b1;
            TYPE_BEQ:  cond = (ex.val1 == ex.src2_val);
            TYPE_BLT:  cond = ($signed(ex.val1) < $signed(ex.src2_val));
            TYPE_BGE:  cond = ($signed(ex.val1) >= $signed(ex.src2_val));
            TYPE_BLTU: cond = (ex.val1 < ex.src2_val);
        endcase
    end

    assign taken           = ex.in_valid & cond;
    assign ex.branch_taken = taken;

    // An instruction arriving while the redirect is out is on the wrong path: squash it.
    assign accept         = ex.in_valid & ~ex.stall & ~redirect_valid_q;
    assign is_branch      = (ex.branch_type != TYPE_NONE);
    assign is_conditional = is_branch & (ex.branch_type != TYPE_JMP);
    assign mispredict     = accept & is_branch & (taken != ex.pred_taken);
    assign bht_update     = accept & is_conditional;

    assign next_pc = taken ? ex.target : (ex.pc + PC_WIDTH'(4));

    assign bht_cur = bht_q[ex_idx];

    always_comb begin
        bht_next = bht_cur;
        if (taken) begin
            if (bht_cur != 2'b11) begin
                bht_next = bht_cur + 2'b01;
            end
        end else begin
            if (bht_cur != 2'b00) begin
                bht_next = bht_cur - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (bht_update) begin
            bht_q[ex_idx] <= bht_next;
        end
    end

    // Stall and squash both drop accept, so the pulse self-clears after one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= mispredict;
            if (mispredict) begin
                redirect_pc_q <= next_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (accept && is_branch && (branch_count_q != '1)) begin
                branch_count_q <= branch_count_q + CNT_WIDTH'(1);
            end
            if (mispredict && (mispredict_count_q != '1)) begin
                mispredict_count_q <= mispredict_count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign ex.redirect_valid = redirect_valid_q;
    assign ex.redirect_pc    = redirect_pc_q;
    assign branch_count      = branch_count_q;
    assign mispredict_count  = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    localparam int unsigned W     = 32;
    localparam int unsigned PW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = 4;
    localparam int          CMAX  = (1 << CW) - 1;
    localparam longint      HALF  = 64'sh8000_0000;
    localparam longint      FULL  = 64'sh1_0000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] if_pc;
    logic          if_pred_taken;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispredict_count;

    branch_resolve_unit_if #(.WIDTH(W), .PC_WIDTH(PW)) bus ();

    branch_resolve_unit #(
        .WIDTH    (W),
        .PC_WIDTH (PW),
        .BHT_DEPTH(DEPTH),
        .CNT_WIDTH(CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_pc           (if_pc),
        .if_pred_taken   (if_pred_taken),
        .ex              (bus),
        .branch_count    (branch_count),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bt;
        logic        ifp;
        logic        rv;
        logic [31:0] rpc;
        int          bc;
        int          mc;
    } status_t;

    status_t     sq[$];
    logic [31:0] rq[$];
    int          vectors = 0;
    int          miscompares = 0;

    // Reference state: what the DUT should hold after the most recent clock edge.
    int          m_bht[DEPTH];
    bit          m_rv;
    logic [31:0] m_rpc;
    int          m_bc;
    int          m_mc;

    function automatic bit model_cond(input int ty, input logic [31:0] a, input logic [31:0] b);
        longint ua, ub, sa, sb;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= HALF) ? ua - FULL : ua;
        sb = (ub >= HALF) ? ub - FULL : ub;
        case (ty)
            1:       return ua == 0;
            2:       return ua != ub;
            3:       return 1'b1;
            4:       return ua == ub;
            5:       return sa < sb;
            6:       return sa >= sb;
            7:       return ua < ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_next_pc(input logic [31:0] p);
        longint t;
        t = (longint'(p) + 4) % FULL;
        return t[31:0];
    endfunction

    function automatic int bidx(input logic [31:0] p);
        return int'((longint'(p) / 4) % DEPTH);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) m_bht[i] = 1;
        m_rv  = 1'b0;
        m_rpc = '0;
        m_bc  = 0;
        m_mc  = 0;
    endtask

    task automatic step(input bit iv, input bit st, input logic [31:0] pc, input logic [31:0] v1,
                        input logic [31:0] v2, input int ty, input logic [31:0] tgt,
                        input bit pt, input logic [31:0] ipc);
        status_t s;
        bit      tk, acc, mis;
        int      bi;
        @(posedge clk);
        #1;
        rst_n            = 1'b1;
        bus.in_valid     = iv;
        bus.stall        = st;
        bus.pc           = pc;
        bus.val1         = v1;
        bus.src2_val     = v2;
        bus.branch_type  = ty[2:0];
        bus.target       = tgt;
        bus.pred_taken   = pt;
        if_pc            = ipc;
        tk    = iv && model_cond(ty, v1, v2);
        s.bt  = tk;
        s.ifp = (m_bht[bidx(ipc)] >= 2);
        s.rv  = m_rv;
        s.rpc = m_rpc;
        s.bc  = m_bc;
        s.mc  = m_mc;
        sq.push_back(s);
        acc  = iv && !st && !m_rv;
        mis  = acc && (ty != 0) && (tk != pt);
        m_rv = mis;
        if (mis) begin
            m_rpc = tk ? tgt : model_next_pc(pc);
            rq.push_back(m_rpc);
        end
        if (acc && ty != 0 && m_bc < CMAX) m_bc++;
        if (mis && m_mc < CMAX) m_mc++;
        if (acc && ty != 0 && ty != 3) begin
            bi = bidx(pc);
            if (tk) m_bht[bi] = (m_bht[bi] < 3) ? m_bht[bi] + 1 : 3;
            else    m_bht[bi] = (m_bht[bi] > 0) ? m_bht[bi] - 1 : 0;
        end
    endtask

    task automatic idle(input logic [31:0] ipc);
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b0, ipc);
    endtask

    // Asserted after an edge so the asynchronous clear is visible before the next edge.
    task automatic do_reset();
        status_t s;
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.stall    = 1'b0;
        if_pc        = $urandom;
        model_reset();
        rq.delete();
        s.bt  = 1'b0;
        s.ifp = 1'b0;
        s.rv  = 1'b0;
        s.rpc = '0;
        s.bc  = 0;
        s.mc  = 0;
        sq.push_back(s);
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'(longint'($urandom_range(0, 7)));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: status popped each sampling edge, redirect target popped when the DUT pulses.
    initial begin
        status_t s;
        forever begin
            @(negedge clk);
            if (sq.size() > 0) begin
                s = sq.pop_front();
                check("branch_taken", 64'(bus.branch_taken), 64'(s.bt));
                check("if_pred_taken", 64'(if_pred_taken), 64'(s.ifp));
                check("redirect_valid", 64'(bus.redirect_valid), 64'(s.rv));
                check("redirect_pc_hold", 64'(bus.redirect_pc), 64'(s.rpc));
                check("branch_count", 64'(branch_count), 64'(s.bc));
                check("mispredict_count", 64'(mispredict_count), 64'(s.mc));
            end
            if (bus.redirect_valid === 1'b1) begin
                if (rq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_redirect: got pulse pc=0x%0h expected none at %0t",
                             bus.redirect_pc, $time);
                end else begin
                    check("redirect_target", 64'(bus.redirect_pc), 64'(rq.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [31:0] pc, v1, v2, ipc;
        int          ty;
        bit          pt;
        bus.in_valid    = 1'b0;
        bus.stall       = 1'b0;
        bus.pc          = '0;
        bus.val1        = '0;
        bus.src2_val    = '0;
        bus.branch_type = '0;
        bus.target      = '0;
        bus.pred_taken  = 1'b0;
        if_pc           = '0;

        do_reset();
        idle(32'h40);
        // BEQ taken, predicted not taken: redirect to target, BHT[0x40] 01 -> 10.
        step(1, 0, 32'h40, 32'd5, 32'd5, 4, 32'h80, 0, 32'h40);
        idle(32'h40);
        idle(32'h40);

        // BLT signed taken (predicted), then BLTU not taken mispredicts to pc+4.
        step(1, 0, 32'h100, 32'hFFFF_FFFF, 32'd1, 5, 32'h300, 1, 32'h100);
        step(1, 0, 32'h100, 32'hFFFF_FFFF, 32'd1, 7, 32'h300, 1, 32'h100);
        idle(32'h100);
        idle(32'h100);

        // BNE taken three times with matching prediction, then one not-taken.
        for (int i = 0; i < 3; i++) step(1, 0, 32'h200, 32'd1, 32'd2, 2, 32'h400, 1, 32'h200);
        idle(32'h200);
        step(1, 0, 32'h200, 32'd3, 32'd3, 2, 32'h400, 1, 32'h200);
        idle(32'h200);
        idle(32'h200);

        // Mispredict followed by a would-be mispredict in the shadow cycle.
        step(1, 0, 32'h20, 32'd0, 32'd9, 1, 32'h60, 0, 32'h20);
        step(1, 0, 32'h24, 32'd7, 32'd8, 4, 32'h64, 1, 32'h24);
        idle(32'h24);

        // Stalled mispredicting BEZ, then released.
        step(1, 1, 32'h30, 32'd0, 32'd0, 1, 32'h90, 0, 32'h30);
        step(1, 1, 32'h30, 32'd0, 32'd0, 1, 32'h90, 0, 32'h30);
        step(1, 0, 32'h30, 32'd0, 32'd0, 1, 32'h90, 0, 32'h30);
        idle(32'h30);
        idle(32'h30);

        // PC wrap on the not-taken path.
        step(1, 0, 32'hFFFF_FFFC, 32'd1, 32'd2, 4, 32'h10, 1, 32'h0);
        idle(32'h0);

        // Saturate both counters, then reset in the middle of a redirect pulse.
        for (int i = 0; i < 18; i++) begin
            step(1, 0, 32'h8, 32'd4, 32'd4, 3, 32'hC0, 0, 32'h8);
            idle(32'h8);
        end
        step(1, 0, 32'h8, 32'd4, 32'd4, 3, 32'hC0, 0, 32'h8);
        do_reset();
        idle(32'h8);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
                continue;
            end
            pc  = 32'(longint'($urandom_range(0, 15)) * 4);
            if ($urandom_range(0, 9) == 0) pc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 49) == 0) pc = 32'hFFFF_FFFC;
            v1  = rand_op();
            v2  = ($urandom_range(0, 3) == 0) ? v1 : rand_op();
            ty  = $urandom_range(0, 7);
            ipc = ($urandom_range(0, 1) == 0) ? pc : 32'(longint'($urandom_range(0, 15)) * 4);
            pt  = ($urandom_range(0, 1) == 0) ? (m_bht[bidx(pc)] >= 2) : 1'($urandom_range(0, 1));
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0), pc, v1, v2, ty,
                 $urandom, pt, ipc);
        end

        idle(32'h0);
        idle(32'h0);
        @(negedge clk);
        @(negedge clk);
        check("leftover_status", 64'(sq.size()), 64'd0);
        check("leftover_redirects", 64'(rq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
